// File: rtl/minn_pkg.sv
// Shared types and helpers for the Minn timing-peak detector.
package minn_pkg;

    localparam int SUM_WIDTH_DEF    = 34;
    localparam int THRESH_WIDTH_DEF = 16;
    localparam int THRESH_FRAC      = THRESH_WIDTH_DEF - 1;
    localparam int ABS_W            = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        BLANK = 2'd2
    } minn_state_e;

    // x is a w-bit signed sum sign-extended to ABS_W; the most-negative
    // w-bit value has no positive twin, so it saturates to the largest one.
    function automatic logic [ABS_W-1:0] sat_abs(input logic [ABS_W-1:0] x, input int w);
        logic [ABS_W-1:0] most_neg;
        most_neg = {ABS_W{1'b1}} << (w - 1);
        if (x == most_neg) begin
            return ~most_neg;
        end
        if (x[ABS_W-1]) begin
            return -x;
        end
        return x;
    endfunction

endpackage

// File: rtl/minn_thresh_compare.sv
// Stage 1 of the peak detector: |corr|, clamped energy, threshold compare and sample index.
// Build option MINN_PEAK_ENERGY_FLOOR_EN adds an energy floor to the hit condition.
module minn_thresh_compare
    import minn_pkg::*;
#(
    parameter int SUM_WIDTH    = SUM_WIDTH_DEF,
    parameter int THRESH_WIDTH = THRESH_WIDTH_DEF,
    parameter int IDX_WIDTH    = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [SUM_WIDTH-1:0] in_corr,
    input  logic signed [SUM_WIDTH-1:0] in_energy,
    input  logic [THRESH_WIDTH-1:0]     cfg_thresh,
`ifdef MINN_PEAK_ENERGY_FLOOR_EN
    input  logic [SUM_WIDTH-1:0]        cfg_energy_floor,
`endif
    output logic                        s1_valid,
    output logic                        s1_hit,
    output logic [SUM_WIDTH-1:0]        s1_mag,
    output logic [IDX_WIDTH-1:0]        s1_idx
);

    localparam int PROD_W = SUM_WIDTH + THRESH_WIDTH;
    localparam int FRAC   = THRESH_WIDTH - 1;

    logic [ABS_W-1:0]     corr_ext;
    logic [SUM_WIDTH-1:0] mag;
    logic [SUM_WIDTH-1:0] en;
    logic [PROD_W-1:0]    lhs;
    logic [PROD_W-1:0]    rhs;
    logic                 hit;

    logic                 valid_q, valid_d;
    logic                 hit_q, hit_d;
    logic [SUM_WIDTH-1:0] mag_q, mag_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [IDX_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        corr_ext = {{(ABS_W - SUM_WIDTH){in_corr[SUM_WIDTH-1]}}, in_corr};
        mag      = SUM_WIDTH'(sat_abs(corr_ext, SUM_WIDTH));
        en       = in_energy[SUM_WIDTH-1] ? '0 : $unsigned(in_energy);
        // Both sides fit PROD_W exactly, so the compare never truncates.
        lhs      = PROD_W'(mag) << FRAC;
        rhs      = PROD_W'(cfg_thresh) * PROD_W'(en);
        hit      = (lhs >= rhs);
`ifdef MINN_PEAK_ENERGY_FLOOR_EN
        hit      = hit && (en >= cfg_energy_floor);
`endif

        valid_d = in_valid;
        hit_d   = hit_q;
        mag_d   = mag_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (in_valid) begin
            hit_d = hit;
            mag_d = mag;
            idx_d = cnt_q;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            mag_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            hit_q   <= hit_d;
            mag_q   <= mag_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s1_valid = valid_q;
    assign s1_hit   = hit_q;
    assign s1_mag   = mag_q;
    assign s1_idx   = idx_q;

endmodule

// File: rtl/minn_peak_detector.sv
// Minn timing-peak detector: tracks the local |corr| maximum above threshold and reports it after hold-off.
// Build option MINN_PEAK_ENERGY_FLOOR_EN adds the cfg_energy_floor input.
//
// state | meaning
// IDLE  | waiting for the first above-threshold sample
// TRACK | holding a candidate maximum, counting beats without a new one
// BLANK | ignoring beats after a report
module minn_peak_detector
    import minn_pkg::*;
#(
    parameter int SUM_WIDTH    = SUM_WIDTH_DEF,
    parameter int THRESH_WIDTH = THRESH_FRAC + 1,
    parameter int IDX_WIDTH    = 20,
    parameter int HOLDOFF      = 64,
    parameter int BLANK_LEN    = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [SUM_WIDTH-1:0] in_corr,
    input  logic signed [SUM_WIDTH-1:0] in_energy,
    input  logic [THRESH_WIDTH-1:0]     cfg_thresh,
`ifdef MINN_PEAK_ENERGY_FLOOR_EN
    input  logic [SUM_WIDTH-1:0]        cfg_energy_floor,
`endif
    output logic                        peak_valid,
    output logic [IDX_WIDTH-1:0]        peak_index,
    output logic [SUM_WIDTH-1:0]        peak_corr,
    output logic                        busy
);

    localparam int HOLD_W  = $clog2(HOLDOFF + 1);
    localparam int BLANK_W = (BLANK_LEN < 2) ? 1 : $clog2(BLANK_LEN + 1);

    logic                 s1_valid;
    logic                 s1_hit;
    logic [SUM_WIDTH-1:0] s1_mag;
    logic [IDX_WIDTH-1:0] s1_idx;

    minn_state_e          state_q, state_d;
    logic [SUM_WIDTH-1:0] max_q, max_d;
    logic [IDX_WIDTH-1:0] max_idx_q, max_idx_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic                 peak_valid_q, peak_valid_d;
    logic [IDX_WIDTH-1:0] peak_index_q, peak_index_d;
    logic [SUM_WIDTH-1:0] peak_corr_q, peak_corr_d;

    minn_thresh_compare #(
        .SUM_WIDTH    (SUM_WIDTH),
        .THRESH_WIDTH (THRESH_WIDTH),
        .IDX_WIDTH    (IDX_WIDTH)
    ) u_thresh (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_corr          (in_corr),
        .in_energy        (in_energy),
        .cfg_thresh       (cfg_thresh),
`ifdef MINN_PEAK_ENERGY_FLOOR_EN
        .cfg_energy_floor (cfg_energy_floor),
`endif
        .s1_valid         (s1_valid),
        .s1_hit           (s1_hit),
        .s1_mag           (s1_mag),
        .s1_idx           (s1_idx)
    );

    always_comb begin
        state_d      = state_q;
        max_d        = max_q;
        max_idx_d    = max_idx_q;
        hold_cnt_d   = hold_cnt_q;
        blank_cnt_d  = blank_cnt_q;
        peak_valid_d = 1'b0;
        peak_index_d = peak_index_q;
        peak_corr_d  = peak_corr_q;

        if (s1_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (s1_hit) begin
                        max_d      = s1_mag;
                        max_idx_d  = s1_idx;
                        hold_cnt_d = '0;
                        state_d    = TRACK;
                    end
                end
                TRACK: begin
                    // Strict compare: an equal later sample never displaces the earlier one.
                    if (s1_hit && (s1_mag > max_q)) begin
                        max_d      = s1_mag;
                        max_idx_d  = s1_idx;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_W'(HOLDOFF - 1)) begin
                        peak_valid_d = 1'b1;
                        peak_index_d = max_idx_q;
                        peak_corr_d  = max_q;
                        blank_cnt_d  = '0;
                        state_d      = (BLANK_LEN == 0) ? IDLE : BLANK;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_cnt_q == BLANK_W'(BLANK_LEN - 1)) begin
                        state_d = IDLE;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            max_q        <= '0;
            max_idx_q    <= '0;
            hold_cnt_q   <= '0;
            blank_cnt_q  <= '0;
            peak_valid_q <= 1'b0;
            peak_index_q <= '0;
            peak_corr_q  <= '0;
        end else begin
            state_q      <= state_d;
            max_q        <= max_d;
            max_idx_q    <= max_idx_d;
            hold_cnt_q   <= hold_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
            peak_valid_q <= peak_valid_d;
            peak_index_q <= peak_index_d;
            peak_corr_q  <= peak_corr_d;
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_index = peak_index_q;
    assign peak_corr  = peak_corr_q;
    assign busy       = (state_q != IDLE);

endmodule
